msrv32_wb_sequencer: RTL

Write-back sequencer driving the single write port of the integer register file (rd address, write enable, rd data).
- Merges single-cycle pipeline results with results from long-latency units (load, divide) through a small FIFO.
- Holds a busy scoreboard of pending long-latency destinations, so hazard logic can stall dependent reads until the result commits.

---
 rtl/msrv32_wb_sequencer_if.sv | 42 ++++
 rtl/msrv32_wb_sequencer.sv | 107 ++++++++++
 2 files changed

// File: rtl/msrv32_wb_sequencer_if.sv
// Write-back sequencer bus: pipeline result, long-latency result handshake,
// issue/hazard scoreboard queries and the registered register-file write port.
interface msrv32_wb_sequencer_if #(
  parameter int CNT_W = 3
);
  // lu_* handshake: a transfer happens at a rising edge where lu_valid_in and
  // lu_ready_out are both 1; the source holds data stable while valid && !ready,
  // and ready never depends combinationally on valid.
  logic             pipe_wr_en_in;
  logic [4:0]       pipe_rd_addr_in;
  logic [31:0]      pipe_rd_in;
  logic             lu_valid_in;
  logic             lu_ready_out;
  logic [4:0]       lu_rd_addr_in;
  logic [31:0]      lu_rd_in;
  logic             issue_en_in;
  logic [4:0]       issue_rd_addr_in;
  logic [4:0]       rs_1_addr_in;
  logic [4:0]       rs_2_addr_in;
  logic             rs_1_busy_out;
  logic             rs_2_busy_out;
  logic [4:0]       rd_addr_out;
  logic             wr_en_out;
  logic [31:0]      rd_out;
  logic [CNT_W-1:0] fifo_count_out;

  modport master (
    output pipe_wr_en_in, pipe_rd_addr_in, pipe_rd_in,
    output lu_valid_in, lu_rd_addr_in, lu_rd_in,
    output issue_en_in, issue_rd_addr_in, rs_1_addr_in, rs_2_addr_in,
    input  lu_ready_out, rs_1_busy_out, rs_2_busy_out,
    input  rd_addr_out, wr_en_out, rd_out, fifo_count_out
  );

  modport slave (
    input  pipe_wr_en_in, pipe_rd_addr_in, pipe_rd_in,
    input  lu_valid_in, lu_rd_addr_in, lu_rd_in,
    input  issue_en_in, issue_rd_addr_in, rs_1_addr_in, rs_2_addr_in,
    output lu_ready_out, rs_1_busy_out, rs_2_busy_out,
    output rd_addr_out, wr_en_out, rd_out, fifo_count_out
  );
endinterface

// File: rtl/msrv32_wb_sequencer.sv
// Register-file write-back sequencer: pipeline results win, long-latency results queue in a FIFO.
// Optional MSRV32_WB_BYPASS_EN sends a long-latency result straight to the output when idle.
module msrv32_wb_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input logic                 clk_in,
  input logic                 reset_in,
  msrv32_wb_sequencer_if.slave wb
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [4:0]       addr_mem [FIFO_DEPTH];
  logic [31:0]      data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      busy;
  logic [31:0]      busy_set;
  logic [31:0]      busy_clr;
  logic             lu_xfer;
  logic             lu_keep;
  logic             fifo_empty;
  logic             bypass;
  logic             push;
  logic             pop;

  // Ready comes from the pre-edge count, so a pop never frees a slot in its own cycle.
  assign wb.lu_ready_out = !reset_in && (count != FULL_CNT);
  assign lu_xfer         = wb.lu_valid_in && wb.lu_ready_out;
  assign lu_keep         = lu_xfer && (wb.lu_rd_addr_in != 5'd0);
  assign fifo_empty      = (count == '0);

`ifdef MSRV32_WB_BYPASS_EN
  assign bypass = lu_keep && fifo_empty && !wb.pipe_wr_en_in;
`else
  assign bypass = 1'b0;
`endif

  assign push = lu_keep && !bypass;
  assign pop  = !wb.pipe_wr_en_in && !fifo_empty;

  always_ff @(posedge clk_in) begin
    if (push) begin
      addr_mem[wr_ptr] <= wb.lu_rd_addr_in;
      data_mem[wr_ptr] <= wb.lu_rd_in;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Set is applied after clear so a same-cycle reissue of a retiring rd stays busy.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (wb.issue_en_in) busy_set[wb.issue_rd_addr_in] = 1'b1;
    if (pop)            busy_clr[addr_mem[rd_ptr]]    = 1'b1;
    if (bypass)         busy_clr[wb.lu_rd_addr_in]    = 1'b1;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) busy <= '0;
    else          busy <= ((busy & ~busy_clr) | busy_set) & 32'hFFFF_FFFE;
  end

  assign wb.rs_1_busy_out = busy[wb.rs_1_addr_in];
  assign wb.rs_2_busy_out = busy[wb.rs_2_addr_in];

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wb.rd_addr_out <= 5'd0;
      wb.rd_out      <= 32'd0;
      wb.wr_en_out   <= 1'b0;
    end else if (wb.pipe_wr_en_in) begin
      wb.rd_addr_out <= wb.pipe_rd_addr_in;
      wb.rd_out      <= wb.pipe_rd_in;
      wb.wr_en_out   <= (wb.pipe_rd_addr_in != 5'd0);
    end else if (pop) begin
      wb.rd_addr_out <= addr_mem[rd_ptr];
      wb.rd_out      <= data_mem[rd_ptr];
      wb.wr_en_out   <= 1'b1;
    end else if (bypass) begin
      wb.rd_addr_out <= wb.lu_rd_addr_in;
      wb.rd_out      <= wb.lu_rd_in;
      wb.wr_en_out   <= 1'b1;
    end else begin
      wb.wr_en_out   <= 1'b0;
    end
  end

  assign wb.fifo_count_out = count;
endmodule
